// File: rtl/video_acc_pkg.sv
// -----------------------------------------------------------------------------
// video_acc_pkg
// Shared types and constants for the video accelerator DMA command path.
//   dm_cmd_t  : 64-bit DataMoverCommand
//               user[63:56] last[55] len[54:40] rsvd[39] addr[38:6] rsvd[5:3] dest[2:0]
//   state_t   : job scheduler FSM states
//   make_cmd(): builds a command with reserved fields forced to zero
// -----------------------------------------------------------------------------
package video_acc_pkg;

   localparam int NR_FUN_UNITS = 3;
   localparam int DEST_WIDTH   = 3;
   localparam int USER_WIDTH   = 8;
   localparam int LINE_SHIFT   = 6;
   localparam int ADDR_MSB     = 38;
   localparam int LINE_ADDR_W  = ADDR_MSB - LINE_SHIFT + 1;   // 33-bit line address
   localparam int CMD_LEN_W    = 15;

   typedef struct packed {
      logic [USER_WIDTH-1:0]  user;
      logic                   last;
      logic [CMD_LEN_W-1:0]   len;
      logic                   rsvd_39;
      logic [LINE_ADDR_W-1:0] addr;
      logic [2:0]             rsvd_5_3;
      logic [DEST_WIDTH-1:0]  dest;
   } dm_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic dm_cmd_t make_cmd(
      input logic [USER_WIDTH-1:0]  user,
      input logic                   last,
      input logic [CMD_LEN_W-1:0]   len,
      input logic [LINE_ADDR_W-1:0] addr,
      input logic [DEST_WIDTH-1:0]  dest
   );
      dm_cmd_t c;
      c.user     = user;
      c.last     = last;
      c.len      = len;
      c.rsvd_39  = 1'b0;
      c.addr     = addr;
      c.rsvd_5_3 = 3'b000;
      c.dest     = dest;
      return c;
   endfunction

endpackage

// File: rtl/video_acc_credit_cnt.sv
// -----------------------------------------------------------------------------
// video_acc_credit_cnt
// Saturating up/down credit counter with a sticky underflow flag.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_inc        : one credit consumed (count +1, saturates at MAX_CNT)
//   i_dec        : one credit returned (count -1); at zero it is ignored and
//                  o_underflow is set until reset
//   o_count      : current count
//   o_underflow  : sticky underflow flag
// -----------------------------------------------------------------------------
module video_acc_credit_cnt #(
   parameter int CNT_W   = 4,
   parameter int MAX_CNT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_underflow
);

   logic [CNT_W-1:0] r_count;
   logic             r_underflow;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else if (i_inc && !i_dec) begin
         if (r_count != CNT_W'(MAX_CNT)) r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc) begin
         if (r_count == '0) r_underflow <= 1'b1;
         else               r_count     <= r_count - 1'b1;
      end
   end

   assign o_count     = r_count;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/video_acc_job_sched.sv
// -----------------------------------------------------------------------------
// video_acc_job_sched
// Splits one frame job into chunks of at most CHUNK_LINES 64-byte lines and
// issues matched source/destination DataMoverCommand pairs, bounded by a
// credit of MAX_OUTST chunks in flight returned through chunk_done.
//   aclk, areset           : clock, synchronous active-high reset
//   job_*                  : descriptor in (valid/ready handshake)
//   src_cmd/valid/ready    : source (read) mover command stream
//   dst_cmd/valid/ready    : destination (write) mover command stream
//   chunk_done             : one pulse per chunk fully written
//   busy, job_done         : status; job_done pulses once per job
//   outstanding            : chunks issued but not completed
//   err_underflow          : sticky, chunk_done with nothing in flight
// -----------------------------------------------------------------------------
module video_acc_job_sched #(
   parameter int CHUNK_LINES  = 64,
   parameter int MAX_OUTST    = 4,
   parameter int LEN_WIDTH    = 24,
   parameter int NR_FUN_UNITS = video_acc_pkg::NR_FUN_UNITS
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [32:0]          job_src_line,
   input  logic [32:0]          job_dst_line,
   input  logic [LEN_WIDTH-1:0] job_lines,
   input  logic [2:0]           job_route,
   input  logic [7:0]           job_user,
   output logic [63:0]          src_cmd,
   output logic                 src_valid,
   input  logic                 src_ready,
   output logic [63:0]          dst_cmd,
   output logic                 dst_valid,
   input  logic                 dst_ready,
   input  logic                 chunk_done,
   output logic                 busy,
   output logic                 job_done,
   output logic [3:0]           outstanding,
   output logic                 err_underflow
);

   import video_acc_pkg::*;

   state_t                 r_state;
   logic                   r_src_valid, r_dst_valid, r_job_done;
   dm_cmd_t                r_src_cmd, r_dst_cmd;
   logic [LINE_ADDR_W-1:0] r_src_addr, r_dst_addr;
   logic [LEN_WIDTH-1:0]   r_remaining;
   logic [DEST_WIDTH-1:0]  r_route;
   logic [USER_WIDTH-1:0]  r_user;

   logic [3:0]             w_outstanding;
   logic                   w_pending, w_pair_done, w_slot_free, w_credit_ok, w_load;
   logic [CMD_LEN_W-1:0]   w_len;
   logic                   w_last;

   // A pair completes on the cycle its last still-valid half is accepted.
   assign w_pending   = r_src_valid | r_dst_valid;
   assign w_pair_done = w_pending & ~(r_src_valid & ~src_ready) & ~(r_dst_valid & ~dst_ready);
   assign w_slot_free = ~w_pending | w_pair_done;

   // Credit looks at the count as it will be after this edge, so a returned
   // credit lets the next pair appear in the very next cycle.
   assign w_credit_ok = ({1'b0, w_outstanding} + 5'(w_pair_done)) < (5'(MAX_OUTST) + 5'(chunk_done));
   assign w_load      = (r_state == ST_ISSUE) & w_slot_free & (r_remaining != '0) & w_credit_ok;

   // NOTE: every variable written in always_comb gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      w_len = CMD_LEN_W'(CHUNK_LINES);
      if (r_remaining < LEN_WIDTH'(CHUNK_LINES)) w_len = CMD_LEN_W'(r_remaining);
   end
   assign w_last = (r_remaining == LEN_WIDTH'(w_len));

   // NOTE: command, address and descriptor registers carry no reset; they are
   // only consumed while a valid or a non-IDLE state qualifies them.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state     <= ST_IDLE;
         r_src_valid <= 1'b0;
         r_dst_valid <= 1'b0;
         r_job_done  <= 1'b0;
         r_remaining <= '0;
      end else begin
         r_job_done <= 1'b0;
         if (r_src_valid && src_ready) r_src_valid <= 1'b0;
         if (r_dst_valid && dst_ready) r_dst_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (job_valid) begin
                  r_src_addr  <= job_src_line;
                  r_dst_addr  <= job_dst_line;
                  r_remaining <= job_lines;
                  r_user      <= job_user;
                  r_route     <= (job_route > 3'(NR_FUN_UNITS)) ? '0 : job_route;
                  if (job_lines == '0) begin
                     r_state    <= ST_DONE;
                     r_job_done <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (w_load) begin
                  r_src_valid <= 1'b1;
                  r_dst_valid <= 1'b1;
                  r_src_cmd   <= make_cmd(r_user, w_last, w_len, r_src_addr, r_route);
                  r_dst_cmd   <= make_cmd('0, 1'b0, w_len, r_dst_addr, '0);
                  r_src_addr  <= r_src_addr + LINE_ADDR_W'(w_len);
                  r_dst_addr  <= r_dst_addr + LINE_ADDR_W'(w_len);
                  r_remaining <= r_remaining - LEN_WIDTH'(w_len);
               end else if (r_remaining == '0 && w_slot_free) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_outstanding == '0) begin
                  r_state    <= ST_DONE;
                  r_job_done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;   // ST_DONE
         endcase
      end
   end

   video_acc_credit_cnt #(
      .CNT_W   (4),
      .MAX_CNT (MAX_OUTST)
   ) u_credit (
      .i_clk       (aclk),
      .i_rst       (areset),
      .i_inc       (w_pair_done),
      .i_dec       (chunk_done),
      .o_count     (w_outstanding),
      .o_underflow (err_underflow)
   );

   assign job_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign job_done    = r_job_done;
   assign src_cmd     = r_src_cmd;
   assign dst_cmd     = r_dst_cmd;
   assign src_valid   = r_src_valid;
   assign dst_valid   = r_dst_valid;
   assign outstanding = w_outstanding;

endmodule

// File: tb/tb_video_acc_job_sched.sv
// -----------------------------------------------------------------------------
// tb_video_acc_job_sched
// Scoreboard bench: expected command pairs are queued when a descriptor is
// accepted and compared as the mover streams accept them.
// -----------------------------------------------------------------------------
module tb_video_acc_job_sched;

   logic        aclk = 1'b0;
   logic        areset;
   logic        job_valid, job_ready;
   logic [32:0] job_src_line, job_dst_line;
   logic [23:0] job_lines;
   logic [2:0]  job_route;
   logic [7:0]  job_user;
   logic [63:0] src_cmd, dst_cmd;
   logic        src_valid, src_ready, dst_valid, dst_ready;
   logic        chunk_done, busy, job_done, err_underflow;
   logic [3:0]  outstanding;

   logic man_done = 1'b0;
   logic auto_done = 1'b0;
   logic auto_en = 1'b0;
   assign chunk_done = man_done | auto_done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int src_cnt = 0, dst_cnt = 0, done_cnt = 0;
   logic [63:0] exp_src[$];
   logic [63:0] exp_dst[$];
   int pend[$];

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   video_acc_job_sched #(
      .CHUNK_LINES(64), .MAX_OUTST(4), .LEN_WIDTH(24), .NR_FUN_UNITS(3)
   ) dut (
      .aclk(aclk), .areset(areset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_src_line(job_src_line), .job_dst_line(job_dst_line),
      .job_lines(job_lines), .job_route(job_route), .job_user(job_user),
      .src_cmd(src_cmd), .src_valid(src_valid), .src_ready(src_ready),
      .dst_cmd(dst_cmd), .dst_valid(dst_valid), .dst_ready(dst_ready),
      .chunk_done(chunk_done), .busy(busy), .job_done(job_done),
      .outstanding(outstanding), .err_underflow(err_underflow)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference chunking of one descriptor into expected command pairs.
   task automatic push_job(input logic [32:0] s, input logic [32:0] d, input logic [23:0] lines,
                           input logic [2:0] route, input logic [7:0] user);
      logic [2:0]  dest;
      int          rem, len;
      logic [32:0] sa, da;
      dest = (route > 3'd3) ? 3'd0 : route;
      rem  = int'(lines);
      sa   = s;
      da   = d;
      while (rem > 0) begin
         len = (rem > 64) ? 64 : rem;
         rem -= len;
         exp_src.push_back({user, (rem == 0), 15'(len), 1'b0, sa, 3'b000, dest});
         exp_dst.push_back({8'h00, 1'b0, 15'(len), 1'b0, da, 3'b000, 3'b000});
         sa = sa + 33'(len);
         da = da + 33'(len);
      end
   endtask

   // Monitor: samples at the falling edge what the next rising edge will accept.
   always @(negedge aclk) begin
      if (areset) begin
         exp_src.delete();
         exp_dst.delete();
         pend.delete();
         auto_done = 1'b0;
         src_cnt   = 0;
         dst_cnt   = 0;
      end else begin
         auto_done = 1'b0;
         if (pend.size() != 0 && pend[0] == cyc) begin
            auto_done = 1'b1;
            void'(pend.pop_front());
         end
         if (job_valid && job_ready)
            push_job(job_src_line, job_dst_line, job_lines, job_route, job_user);
         if (src_valid && src_ready) begin
            check("order_src_after_dst", 64'(src_cnt), 64'(dst_cnt));
            check("src_expected_avail", 64'(exp_src.size() != 0), 64'd1);
            if (exp_src.size() != 0) check("src_cmd", src_cmd, exp_src.pop_front());
            src_cnt++;
         end
         if (dst_valid && dst_ready) begin
            check("dst_expected_avail", 64'(exp_dst.size() != 0), 64'd1);
            if (exp_dst.size() != 0) check("dst_cmd", dst_cmd, exp_dst.pop_front());
            dst_cnt++;
            if (auto_en) pend.push_back(cyc + 10);
         end
         if (job_done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic peek();
      @(negedge aclk);
      #1;
   endtask

   task automatic submit(input logic [32:0] s, input logic [32:0] d, input logic [23:0] lines,
                         input logic [2:0] route, input logic [7:0] user);
      int n = 0;
      step();
      job_src_line = s;
      job_dst_line = d;
      job_lines    = lines;
      job_route    = route;
      job_user     = user;
      job_valid    = 1'b1;
      peek();
      while (!job_ready && n < 200) begin
         peek();
         n++;
      end
      check("job_accept_timeout", 64'(job_ready), 64'd1);
      step();
      job_valid    = 1'b0;
      job_src_line = 'x;
      job_dst_line = 'x;
      job_lines    = 'x;
      job_route    = 'x;
      job_user     = 'x;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin
         peek();
         n++;
      end
      check(tag, 64'(done_cnt - start), 64'd1);
   endtask

   // Returns a credit whenever one is in flight, until the job completes.
   task automatic drain_manual(input int budget, input string tag);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin
         peek();
         man_done = (outstanding != 4'd0);
         n++;
      end
      man_done = 1'b0;
      check(tag, 64'(done_cnt - start), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1);
   end

   initial begin
      int s0, d0, dn0;
      logic [63:0] exp0;
      areset = 1'b1;
      job_valid = 1'b0;
      job_src_line = '0; job_dst_line = '0; job_lines = '0; job_route = '0; job_user = '0;
      src_ready = 1'b1;
      dst_ready = 1'b1;
      repeat (3) step();
      areset = 1'b0;
      peek();
      check("rst_job_ready", 64'(job_ready), 64'd1);
      check("rst_valids", 64'({src_valid, dst_valid, job_done, busy}), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err", 64'(err_underflow), 64'd0);

      // 1: 200 lines -> 64,64,64,8; dst address wraps at 33 bits.
      auto_en = 1'b1;
      s0 = src_cnt; dn0 = done_cnt;
      submit(33'h0_1234_5600, 33'h1_FFFF_FFC0, 24'd200, 3'd2, 8'hA5);
      peek();
      check("t1_no_pair_in_accept_cycle", 64'(src_valid), 64'd0);
      peek();
      check("t1_first_pair_after_1", 64'({src_valid, dst_valid}), 64'b11);
      wait_done(300, "t1_job_done");
      peek();
      check("t1_done_one_pulse", 64'({job_done, job_ready}), 64'b01);
      check("t1_src_pairs", 64'(src_cnt - s0), 64'd4);
      check("t1_exp_empty", 64'(exp_src.size() + exp_dst.size()), 64'd0);
      check("t1_outstanding", 64'(outstanding), 64'd0);
      check("t1_done_count", 64'(done_cnt - dn0), 64'd1);

      // 2: zero-length job.
      s0 = src_cnt;
      submit(33'h0_0000_0100, 33'h0_0000_0200, 24'd0, 3'd1, 8'h01);
      peek();
      check("t2_done_pulse", 64'({job_done, job_ready, src_valid, dst_valid}), 64'b1000);
      peek();
      check("t2_ready_back", 64'({job_done, job_ready}), 64'b01);
      check("t2_no_cmds", 64'(src_cnt - s0), 64'd0);

      // 3: credit stall at MAX_OUTST, one credit releases the fifth pair.
      auto_en = 1'b0;
      s0 = src_cnt; d0 = dst_cnt;
      submit(33'h0_0040_0000, 33'h0_0080_0000, 24'd512, 3'd3, 8'h5A);
      repeat (30) peek();
      check("t3_src_pairs_stall", 64'(src_cnt - s0), 64'd4);
      check("t3_dst_pairs_stall", 64'(dst_cnt - d0), 64'd4);
      check("t3_outstanding_full", 64'(outstanding), 64'd4);
      check("t3_stalled", 64'({src_valid, dst_valid, busy}), 64'b001);
      man_done = 1'b1;
      peek();
      man_done = 1'b0;
      check("t3_fifth_pair_next", 64'({src_valid, dst_valid}), 64'b11);
      check("t3_outstanding_after_credit", 64'(outstanding), 64'd3);
      drain_manual(400, "t3_job_done");
      check("t3_total_pairs", 64'(src_cnt - s0), 64'd8);
      check("t3_no_underflow", 64'(err_underflow), 64'd0);

      // 4: destination back-pressure holds dst_cmd and blocks the next src.
      auto_en = 1'b1;
      step();
      dst_ready = 1'b0;
      s0 = src_cnt; d0 = dst_cnt;
      exp0 = {8'h00, 1'b0, 15'd64, 1'b0, 33'h0_0AB0_0000, 6'b000000};
      submit(33'h0_0000_1000, 33'h0_0AB0_0000, 24'd200, 3'd1, 8'h11);
      for (int i = 0; i < 20; i++) begin
         peek();
         if (i % 5 == 4) begin
            check("t4_dst_held_valid", 64'({src_valid, dst_valid}), 64'b01);
            check("t4_dst_held_cmd", dst_cmd, exp0);
         end
      end
      check("t4_src_once", 64'(src_cnt - s0), 64'd1);
      check("t4_dst_none", 64'(dst_cnt - d0), 64'd0);
      step();
      dst_ready = 1'b1;
      wait_done(300, "t4_job_done");
      check("t4_total_pairs", 64'(dst_cnt - d0), 64'd4);

      // 5: chunk_done coincident with pair completion; then underflow in IDLE.
      auto_en = 1'b0;
      submit(33'h0_0000_2000, 33'h0_0000_4000, 24'd128, 3'd0, 8'h22);
      peek();
      peek();
      check("t5_pair1", 64'({src_valid, outstanding}), {59'd0, 1'b1, 4'd0});
      peek();
      check("t5_pair2", 64'({src_valid, outstanding}), {59'd0, 1'b1, 4'd1});
      man_done = 1'b1;
      peek();
      man_done = 1'b0;
      check("t5_coincident_unchanged", 64'(outstanding), 64'd1);
      drain_manual(200, "t5_job_done");
      peek();
      check("t5_err_clear_before", 64'(err_underflow), 64'd0);
      man_done = 1'b1;
      peek();
      man_done = 1'b0;
      check("t5_underflow_set", 64'({err_underflow, outstanding}), {59'd0, 1'b1, 4'd0});
      repeat (5) peek();
      check("t5_underflow_sticky", 64'(err_underflow), 64'd1);

      // 6: reset mid-issue, then a job with an out-of-range route.
      auto_en = 1'b1;
      step();
      src_ready = 1'b0;
      dst_ready = 1'b0;
      submit(33'h0_0000_8000, 33'h0_0001_0000, 24'd512, 3'd2, 8'h33);
      peek();
      peek();
      check("t6_valids_high", 64'({src_valid, dst_valid}), 64'b11);
      areset = 1'b1;
      peek();
      areset = 1'b0;
      check("t6_rst_valids", 64'({src_valid, dst_valid, busy}), 64'b000);
      check("t6_rst_state", 64'({job_ready, err_underflow, outstanding}), {58'd0, 1'b1, 1'b0, 4'd0});
      step();
      src_ready = 1'b1;
      dst_ready = 1'b1;
      submit(33'h1_2345_6780, 33'h0_0765_4300, 24'd100, 3'd6, 8'h3C);
      peek();
      peek();
      check("t6_route_clamped", 64'({src_valid, src_cmd[2:0]}), {60'd0, 1'b1, 3'd0});
      wait_done(300, "t6_job_done");
      check("t6_pairs", 64'({src_cnt, dst_cnt}), {32'd2, 32'd2});
      check("end_exp_empty", 64'(exp_src.size() + exp_dst.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
